// File: rtl/floppy_dma_pkg.sv
// rtl/floppy_dma_pkg.sv - shared states, completion codes and direction constants for floppy_dma_xfer
package floppy_dma_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_XFER   = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_TC_EARLY = 2'b01;
    localparam logic [1:0] ST_ABORTED  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    localparam logic DIR_RD = 1'b0;
    localparam logic DIR_WR = 1'b1;

endpackage

// File: rtl/floppy_dma_watchdog.sv
// rtl/floppy_dma_watchdog.sv - idle-cycle watchdog; expire fires on the cycle the count would reach LIMIT
module floppy_dma_watchdog #(
    parameter logic [23:0] LIMIT = 24'd1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [23:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= 24'd0;
        end else if (clear) begin
            count <= 24'd0;
        end else if (enable) begin
            count <= count + 24'd1;
        end
    end

    assign expire = enable && !clear && (count == LIMIT - 24'd1);

endmodule

// File: rtl/floppy_dma_xfer.sv
// rtl/floppy_dma_xfer.sv - FIFO <-> 8237 DMA byte mover; FLOPPY_DMA_TIMEOUT_EN adds the idle watchdog
module floppy_dma_xfer
    import floppy_dma_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dir,
    input  logic [15:0] byte_count,
    input  logic        abort,
    input  logic        fifo_empty,
    input  logic        fifo_full,
    input  logic [7:0]  fifo_q,
    output logic        fifo_rdreq,
    output logic        fifo_wrreq,
    output logic [7:0]  fifo_data,
    output logic        fifo_sclr,
    output logic        dreq,
    input  logic        dack,
    input  logic        dma_strobe,
    input  logic        dma_tc,
    input  logic [7:0]  dma_wdata,
    output logic [7:0]  dma_rdata,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [15:0] remaining
);

    state_t      state, state_nx;
    logic        dir_r;
    logic [15:0] rem_r;
    logic [1:0]  status_r, status_nx;
    logic        avail, accept, wd_expire;

    assign avail  = (dir_r == DIR_WR) ? !fifo_full : !fifo_empty;
    // Abort wins over a same-cycle strobe, so it blocks acceptance outright.
    assign accept = (state == S_XFER) && dack && dma_strobe && avail && !abort;

`ifdef FLOPPY_DMA_TIMEOUT_EN
    floppy_dma_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (((state == S_IDLE) && start) || accept),
        .enable (state == S_XFER),
        .expire (wd_expire)
    );
`else
    // Parameter stays on the interface so instantiations build either way.
    assign wd_expire = (TIMEOUT_CYCLES == 24'd0) && 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            dir_r    <= DIR_RD;
            rem_r    <= 16'd0;
            status_r <= ST_OK;
        end else begin
            state    <= state_nx;
            status_r <= status_nx;
            if ((state == S_IDLE) && start) begin
                dir_r <= dir;
                rem_r <= byte_count;
            end else if (accept && (rem_r != 16'd0)) begin
                rem_r <= rem_r - 16'd1;
            end
        end
    end

    always_comb begin
        state_nx   = state;
        status_nx  = status_r;
        dreq       = 1'b0;
        fifo_rdreq = 1'b0;
        fifo_wrreq = 1'b0;
        fifo_data  = 8'h00;
        dma_rdata  = 8'h00;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (byte_count == 16'd0) begin
                        state_nx  = S_FINISH;
                        status_nx = ST_OK;
                    end else begin
                        state_nx = S_XFER;
                    end
                end
            end
            S_XFER: begin
                dreq = avail;
                if ((dir_r == DIR_RD) && dack) begin
                    dma_rdata = fifo_q;
                end
                fifo_rdreq = accept && (dir_r == DIR_RD);
                fifo_wrreq = accept && (dir_r == DIR_WR);
                if (accept && (dir_r == DIR_WR)) begin
                    fifo_data = dma_wdata;
                end
                if (abort) begin
                    state_nx  = S_FINISH;
                    status_nx = ST_ABORTED;
                end else if (accept) begin
                    if (rem_r == 16'd1) begin
                        state_nx  = S_FINISH;
                        status_nx = ST_OK;
                    end else if (dma_tc) begin
                        state_nx  = S_FINISH;
                        status_nx = ST_TC_EARLY;
                    end
                end else if (wd_expire) begin
                    state_nx  = S_FINISH;
                    status_nx = ST_TIMEOUT;
                end
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_FINISH);
    assign fifo_sclr = done && ((status_r == ST_ABORTED) || (status_r == ST_TIMEOUT));
    assign status    = status_r;
    assign remaining = rem_r;

endmodule
